// File: rtl/comple_pkg.sv
// comple_serial shared types: operation modes and FSM states.
// Optional build macro used by the unit: COMPLE_SAT_EN.
package comple_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ONES = 2'b01,
    MODE_TWOS = 2'b10,
    MODE_ABS  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // abs collapses to two's for negative operands, pass otherwise
  function automatic mode_e resolve_op(
    input logic [1:0] m,
    input logic       sign
  );
    mode_e op;
    op = mode_e'(m);
    if (op == MODE_ABS)
      op = sign ? MODE_TWOS : MODE_PASS;
    return op;
  endfunction

endpackage

// File: rtl/comple_bit_cell.sv
// comple_bit_cell: one-bit LSB-first complement rule.
// Two's complement copies bits up to and including the first 1, then inverts.
import comple_pkg::*;

module comple_bit_cell (
  input  logic  i_b,
  input  logic  i_seen,
  input  mode_e i_op,
  output logic  o_r,
  output logic  o_seen
);

  always_comb begin
    o_r    = i_b;
    o_seen = i_seen;
    unique case (i_op)
      MODE_ONES: o_r = ~i_b;
      MODE_TWOS: begin
        o_r    = i_seen ? ~i_b : i_b;
        o_seen = i_seen | i_b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/comple_serial.sv
// comple_serial: bit-serial pass/one's/two's/abs unit, valid/ready in and out.
// Define COMPLE_SAT_EN to saturate the overflowing result to max positive.
import comple_pkg::*;

module comple_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             busy
);

  state_e           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  mode_e            r_op;
  logic             r_ovf_pend;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_busy;

  mode_e            w_eff;
  logic             w_ovf_next;
  logic             w_r;
  logic             w_seen_nx;
  logic [WIDTH-1:0] w_min;
  logic [WIDTH-1:0] w_res_nx;
  logic [WIDTH-1:0] w_final;
  logic             w_last;

  assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_eff      = resolve_op(mode, inp[WIDTH-1]);
  assign w_ovf_next = (w_eff == MODE_TWOS) && (inp == w_min);
  assign w_res_nx   = {w_r, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH-1));

`ifdef COMPLE_SAT_EN
  assign w_final = r_ovf_pend ? {1'b0, {(WIDTH-1){1'b1}}} : w_res_nx;
`else
  assign w_final = w_res_nx;
`endif

  comple_bit_cell u_cell (
    .i_b    (r_sr[0]),
    .i_seen (r_seen),
    .i_op   (r_op),
    .o_r    (w_r),
    .o_seen (w_seen_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_seen      <= 1'b0;
      r_op        <= MODE_PASS;
      r_ovf_pend  <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sr       <= inp;
            r_res      <= '0;
            r_cnt      <= '0;
            r_seen     <= 1'b0;
            r_op       <= w_eff;
            r_ovf_pend <= w_ovf_next;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_res  <= w_res_nx;
          r_sr   <= r_sr >> 1;
          r_seen <= w_seen_nx;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out       <= w_final;
            r_ovf       <= r_ovf_pend;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_comple_serial.sv
// tb_comple_serial: directed table, sweep with mode scrambling, backpressure, reset abort.
`timescale 1ns/1ps
module tb_comple_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inp;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       ovf;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comple_serial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0] m;
    logic [7:0] x;
    logic [7:0] eo;
    logic       ev;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: signed arithmetic on the integer value
  function automatic void model(input logic [1:0] m, input logic [7:0] x,
                                output logic [7:0] o, output logic v);
    int s;
    int r;
    s = int'($signed(x));
    case (m)
      2'd0:    r = s;
      2'd1:    r = ~s;
      2'd2:    r = -s;
      default: r = (s < 0) ? -s : s;
    endcase
    v = (r > 127);
    o = r[7:0];
`ifdef COMPLE_SAT_EN
    if (v) o = 8'h7F;
`endif
  endfunction

  task automatic do_word(input logic [1:0] m, input logic [7:0] x, input bit scr,
                         output logic [7:0] o, output logic v, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    mode = m;
    inp = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (scr) begin
      mode = 2'($urandom);
      inp = 8'($urandom);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 50) chk("out_valid_timeout", 0, 1);
    o = out;
    v = ovf;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t       tbl[10];
  logic [7:0] o;
  logic [7:0] eo;
  logic       v;
  logic       ev;
  int         lat;
  int         n;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inp = '0;
    mode = '0;

    tbl[0] = '{2'b10, 8'h05, 8'hFB, 1'b0};
    tbl[1] = '{2'b01, 8'hA5, 8'h5A, 1'b0};
    tbl[2] = '{2'b00, 8'h3C, 8'h3C, 1'b0};
    tbl[3] = '{2'b11, 8'hF0, 8'h10, 1'b0};
    tbl[4] = '{2'b11, 8'h7F, 8'h7F, 1'b0};
`ifdef COMPLE_SAT_EN
    tbl[5] = '{2'b11, 8'h80, 8'h7F, 1'b1};
    tbl[6] = '{2'b10, 8'h80, 8'h7F, 1'b1};
`else
    tbl[5] = '{2'b11, 8'h80, 8'h80, 1'b1};
    tbl[6] = '{2'b10, 8'h80, 8'h80, 1'b1};
`endif
    tbl[7] = '{2'b10, 8'h00, 8'h00, 1'b0};
    tbl[8] = '{2'b11, 8'h00, 8'h00, 1'b0};
    tbl[9] = '{2'b01, 8'hFF, 8'h00, 1'b0};

    #2;
    chk("rst_out", out, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    foreach (tbl[i]) begin
      do_word(tbl[i].m, tbl[i].x, 1'b0, o, v, lat);
      chk($sformatf("tbl%0d_out", i), o, tbl[i].eo);
      chk($sformatf("tbl%0d_ovf", i), v, tbl[i].ev);
      chk($sformatf("tbl%0d_lat", i), lat, 8);
      chk($sformatf("tbl%0d_rdy", i), {out_valid, in_ready}, 2'b01);
    end

    for (int m = 0; m < 4; m++) begin
      for (int x = 0; x < 256; x++) begin
        model(2'(m), 8'(x), eo, ev);
        do_word(2'(m), 8'(x), 1'b1, o, v, lat);
        chk($sformatf("sw_m%0d_x%0h_out", m, x), o, eo);
        chk($sformatf("sw_m%0d_x%0h_ovf", m, x), v, ev);
      end
    end

    for (int k = 0; k < 100; k++) begin
      logic [1:0] rm;
      logic [7:0] rx;
      rm = 2'($urandom);
      rx = 8'($urandom);
      model(rm, rx, eo, ev);
      do_word(rm, rx, 1'b1, o, v, lat);
      chk($sformatf("rnd%0d_out", k), o, eo);
      chk($sformatf("rnd%0d_ovf", k), v, ev);
      chk($sformatf("rnd%0d_lat", k), lat, 8);
    end

    // backpressure in DONE with a stray in_valid pulse
    @(negedge clk);
    in_valid = 1'b1;
    mode = 2'b10;
    inp = 8'h05;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_lat", n, 8);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_valid = 1'b1;
        mode = 2'b00;
        inp = 8'h11;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("bp%0d_out", c), out, 8'hFB);
      chk($sformatf("bp%0d_ovf", c), ovf, 1'b0);
      chk($sformatf("bp%0d_vr", c), {out_valid, in_ready, busy}, 3'b101);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_rel", {out_valid, in_ready, busy}, 3'b010);
    chk("bp_hold_out", out, 8'hFB);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_noqueue", {out_valid, busy}, 2'b00);

    // asynchronous reset during the third SHIFT cycle
    @(negedge clk);
    in_valid = 1'b1;
    mode = 2'b00;
    inp = 8'h3C;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("ar_busy_pre", busy, 1'b1);
    chk("ar_out_pre", out, 8'hFB);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_out", out, 8'h00);
    chk("ar_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_word(2'b10, 8'h01, 1'b0, o, v, lat);
    chk("ar_new_out", o, 8'hFF);
    chk("ar_new_ovf", v, 1'b0);
    chk("ar_new_lat", lat, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
